lcd_text_renderer: RTL and testbench

- Character-cell text renderer for the 480x272 LCD path: turns LCD timing-generator pixel coordinates into RGB565 pixels.
- Issues character-code reads to the text VRAM (BSRAM), then glyph-row reads to the 4096x8 font pROM (256 glyphs x 16 rows, 8 px wide, MSB = leftmost pixel).
- Fixed 3-stage pipeline; delays sync/DE to match. Adds a blinking block cursor.
- Sits between the LCD timing generator and the LCD pins; sole master of the font ROM and of the VRAM read port.

---
 rtl/lcd_text_renderer.sv | 162 ++++++++++++++++
 tb/tb_lcd_text_renderer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_renderer.sv
// Character-cell text renderer: maps LCD timing coordinates to RGB565 pixels
// through a text VRAM lookup and a font ROM lookup, with a blinking block cursor.
module lcd_text_renderer #(
    parameter int unsigned COLS         = 60,
    parameter int unsigned ROWS         = 17,
    parameter int unsigned VRAM_AW      = 10,
    parameter logic [15:0] FG_COLOR     = 16'hFFFF,
    parameter logic [15:0] BG_COLOR     = 16'h0000,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [9:0]         x_in,
    input  logic [9:0]         y_in,
    output logic               vram_ce,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_dout,
    output logic               font_ce,
    output logic               font_oce,
    output logic [11:0]        font_ad,
    input  logic [7:0]         font_dout,
    input  logic               cursor_en,
    input  logic [5:0]         cursor_col,
    input  logic [4:0]         cursor_row,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [15:0]        rgb_out
);

    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    // Stage 0 cell decode
    logic [6:0] col;
    logic [5:0] row;
    logic       in_area0;
    logic       hit0;

    // Stage 1 sideband
    logic       area1;
    logic [2:0] xbit1;
    logic [3:0] yrow1;
    logic       hit1;
    logic       de1, hs1, vs1;

    // Stage 2 sideband
    logic       area2;
    logic [2:0] xbit2;
    logic       hit2;
    logic       de2, hs2, vs2;

    // Blink state
    logic               vs_prev;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic pix;
    logic on;

    assign font_oce = 1'b1;

    // Decode the character cell and cursor match from the incoming coordinate
    always_comb begin
        col      = x_in[9:3];
        row      = y_in[9:4];
        in_area0 = de_in && (32'(col) < COLS) && (32'(row) < ROWS);
        hit0     = cursor_en && (col == 7'(cursor_col)) && (row == 6'(cursor_row));
    end

    // Stage 1: issue the VRAM read and carry sideband forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_ce   <= 1'b0;
            vram_addr <= '0;
            area1     <= 1'b0;
            xbit1     <= '0;
            yrow1     <= '0;
            hit1      <= 1'b0;
            de1       <= 1'b0;
            hs1       <= 1'b0;
            vs1       <= 1'b0;
        end else begin
            vram_ce   <= in_area0;
            vram_addr <= VRAM_AW'(32'(row) * COLS + 32'(col));
            area1     <= in_area0;
            xbit1     <= x_in[2:0];
            yrow1     <= y_in[3:0];
            hit1      <= hit0;
            de1       <= de_in;
            hs1       <= hsync_in;
            vs1       <= vsync_in;
        end
    end

    // Stage 2: issue the glyph-row read using the returned character code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            font_ce <= 1'b0;
            font_ad <= '0;
            area2   <= 1'b0;
            xbit2   <= '0;
            hit2    <= 1'b0;
            de2     <= 1'b0;
            hs2     <= 1'b0;
            vs2     <= 1'b0;
        end else begin
            font_ce <= area1;
            font_ad <= {vram_dout, yrow1};
            area2   <= area1;
            xbit2   <= xbit1;
            hit2    <= hit1;
            de2     <= de1;
            hs2     <= hs1;
            vs2     <= vs1;
        end
    end

    // Select the glyph bit (MSB is leftmost) and apply the cursor inversion
    always_comb begin
        pix = font_dout[~xbit2];
        on  = pix ^ (hit2 & blink_phase);
    end

    // Output register: pixel colour plus delayed syncs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= BG_COLOR;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb_out   <= (area2 && on) ? FG_COLOR : BG_COLOR;
            de_out    <= de2;
            hsync_out <= hs2;
            vsync_out <= vs2;
        end
    end

    // Cursor blink: toggle phase every BLINK_FRAMES vsync rising edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev     <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            vs_prev <= vsync_in;
            if (vsync_in && !vs_prev) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_renderer.sv
// Bench for lcd_text_renderer: behavioural VRAM/ROM plus a pixel-level reference model.
module tb_lcd_text_renderer;

    localparam int BF   = 2;
    localparam int NCOL = 60;
    localparam int NROW = 17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de_in, hsync_in, vsync_in;
    logic [9:0]  x_in, y_in;
    logic        vram_ce;
    logic [9:0]  vram_addr;
    logic [7:0]  vram_dout;
    logic        font_ce, font_oce;
    logic [11:0] font_ad;
    logic [7:0]  font_dout;
    logic        cursor_en;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        de_out, hsync_out, vsync_out;
    logic [15:0] rgb_out;

    logic [7:0] vram [0:1023];
    logic [7:0] rom  [0:4095];

    assign vram_dout = vram[vram_addr];
    assign font_dout = rom[font_ad];

    always #5 clk = ~clk;

    lcd_text_renderer #(.BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x_in(x_in), .y_in(y_in), .vram_ce(vram_ce), .vram_addr(vram_addr),
        .vram_dout(vram_dout), .font_ce(font_ce), .font_oce(font_oce), .font_ad(font_ad),
        .font_dout(font_dout), .cursor_en(cursor_en), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .de_out(de_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .rgb_out(rgb_out)
    );

    typedef struct {
        logic de, hs, vs;
        int   x, y;
        logic cen;
        int   ccol, crow;
    } px_t;

    px_t         hist[$];
    int          rises;
    logic        vs_seen;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_rgb;
    logic        exp_de, exp_hs, exp_vs;

    // Reference pixel: text cell lookup, glyph bit, cursor XOR with blink phase
    function automatic logic [15:0] model_rgb(input px_t p, input int r);
        int col, row;
        logic [7:0] code, glyph;
        logic pix, hit, phase;
        col = p.x / 8;
        row = p.y / 16;
        if (!p.de || col >= NCOL || row >= NROW) return 16'h0000;
        code  = vram[row * NCOL + col];
        glyph = rom[int'(code) * 16 + p.y % 16];
        pix   = glyph[7 - p.x % 8];
        hit   = p.cen && (col == p.ccol) && (row == p.crow);
        phase = ((r / BF) % 2) == 0;
        return (pix ^ (hit & phase)) ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic px_t idle_px();
        px_t p;
        p = '{de: 1'b0, hs: 1'b0, vs: 1'b0, x: 0, y: 0, cen: 1'b0, ccol: 0, crow: 0};
        return p;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(idle_px());
        hist.push_back(idle_px());
        rises   = 0;
        vs_seen = 1'b0;
    endtask

    // Apply one pixel of inputs, clock it in, and compute the expected outputs now visible
    task automatic tick(input logic de, input logic hs, input logic vs, input int x, input int y,
                        input logic cen, input int ccol, input int crow);
        px_t p;
        int  rb;
        de_in = de; hsync_in = hs; vsync_in = vs;
        x_in = 10'(x); y_in = 10'(y);
        cursor_en = cen; cursor_col = 6'(ccol); cursor_row = 5'(crow);
        p = '{de: de, hs: hs, vs: vs, x: x, y: y, cen: cen, ccol: ccol, crow: crow};
        @(posedge clk);
        rb = rises;
        if (vs && !vs_seen) rises++;
        vs_seen = vs;
        hist.push_back(p);
        #1;
        exp_rgb = model_rgb(hist[0], rb);
        exp_de  = hist[0].de;
        exp_hs  = hist[0].hs;
        exp_vs  = hist[0].vs;
        void'(hist.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            de_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            x_in = 10'($urandom_range(0, 100)); y_in = 10'($urandom_range(0, 100));
            @(posedge clk); #1;
            total++;
            if (de_out !== 1'b0 || rgb_out !== 16'h0000) begin
                bad++; $display("FAIL reset_out: de_out=%b rgb=%h want 0/0000", de_out, rgb_out);
            end
            total++;
            if (vram_ce !== 1'b0 || font_ce !== 1'b0) begin
                bad++; $display("FAIL reset_ce: vram_ce=%b font_ce=%b want 0/0", vram_ce, font_ce);
            end
        end
        total++;
        if (font_oce !== 1'b1) begin
            bad++; $display("FAIL font_oce: got %b want 1", font_oce);
        end
        de_in = 0; hsync_in = 0; vsync_in = 0; x_in = 0; y_in = 0;
        rst_n = 1'b1;
        model_reset();
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (de_out !== 1'b0) begin bad++; $display("FAIL first_de_c1: got %b want 0", de_out); end
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (de_out !== 1'b0) begin bad++; $display("FAIL first_de_c2: got %b want 0", de_out); end
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (de_out !== 1'b1) begin bad++; $display("FAIL first_de_c3: got %b want 1", de_out); end
        total++;
        if (rgb_out !== exp_rgb) begin bad++; $display("FAIL first_rgb: got %h want %h", rgb_out, exp_rgb); end
        idle(2);
    endtask

    task automatic test_addr_map();
        vram[121] = 8'h41;
        tick(1, 0, 0, 15, 37, 0, 0, 0);
        total++;
        if (vram_addr !== 10'd121 || vram_ce !== 1'b1) begin
            bad++; $display("FAIL addr_map: addr=%0d ce=%b want 121/1", vram_addr, vram_ce);
        end
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (font_ad !== 12'h415 || font_ce !== 1'b1) begin
            bad++; $display("FAIL font_ad: ad=%h ce=%b want 415/1", font_ad, font_ce);
        end
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (rgb_out !== exp_rgb || de_out !== 1'b1) begin
            bad++; $display("FAIL addr_pix: rgb=%h de=%b want %h/1", rgb_out, de_out, exp_rgb);
        end
        idle(2);
    endtask

    task automatic test_glyph();
        logic [15:0] want [0:7];
        want = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 1024; i++) vram[i] = 8'h41;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h415] = 8'b1010_0000;
        for (int t = 0; t < 10; t++) begin
            if (t < 8) tick(1, 0, 0, t, 5, 0, 0, 0);
            else       tick(0, 0, 0, 0, 0, 0, 0, 0);
            if (t >= 2) begin
                total++;
                if (rgb_out !== want[t-2] || rgb_out !== exp_rgb) begin
                    bad++; $display("FAIL glyph_x%0d: got %h want %h", t - 2, rgb_out, want[t-2]);
                end
            end
        end
        idle(1);
    endtask

    task automatic test_out_of_area();
        tick(1, 0, 0, 480, 0, 0, 0, 0);
        total++;
        if (vram_ce !== 1'b0) begin bad++; $display("FAIL ooa_x_vce: got %b want 0", vram_ce); end
        tick(1, 0, 0, 0, 272, 0, 0, 0);
        total++;
        if (vram_ce !== 1'b0 || font_ce !== 1'b0) begin
            bad++; $display("FAIL ooa_y_ce: vce=%b fce=%b want 0/0", vram_ce, font_ce);
        end
        tick(1, 0, 0, 479, 271, 0, 0, 0);
        total++;
        if (rgb_out !== 16'h0000 || de_out !== 1'b1 || font_ce !== 1'b0) begin
            bad++; $display("FAIL ooa_x_pix: rgb=%h de=%b fce=%b want 0000/1/0", rgb_out, de_out, font_ce);
        end
        total++;
        if (vram_ce !== 1'b1 || vram_addr !== 10'd1019) begin
            bad++; $display("FAIL edge_cell: vce=%b addr=%0d want 1/1019", vram_ce, vram_addr);
        end
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (rgb_out !== 16'h0000) begin bad++; $display("FAIL ooa_y_pix: got %h want 0000", rgb_out); end
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (rgb_out !== exp_rgb) begin bad++; $display("FAIL edge_pix: got %h want %h", rgb_out, exp_rgb); end
        idle(2);
    endtask

    task automatic test_cursor_blink();
        logic [15:0] want;
        for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        for (int f = 0; f < 8; f++) begin
            logic cen;
            cen  = (f < 6);
            want = (cen && ((f / 2) % 2) == 0) ? 16'hFFFF : 16'h0000;
            for (int t = 0; t < 6; t++) begin
                if (t < 4) tick(1, 0, 0, t, 0, cen, 0, 0);
                else       tick(0, 0, 0, 0, 0, cen, 0, 0);
                if (t >= 2) begin
                    total++;
                    if (rgb_out !== want || rgb_out !== exp_rgb) begin
                        bad++; $display("FAIL blink_f%0d: got %h want %h", f, rgb_out, want);
                    end
                end
            end
            tick(0, 0, 1, 0, 0, cen, 0, 0);
            tick(0, 0, 1, 0, 0, cen, 0, 0);
            tick(0, 0, 0, 0, 0, cen, 0, 0);
        end
        idle(2);
    endtask

    task automatic test_random();
        logic hs, vs, cen;
        int   ccol, crow, x, y;
        hs = 0; vs = 0; cen = 1; ccol = 3; crow = 2;
        for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        for (int n = 0; n < 2000; n++) begin
            if (n % 64 == 0) begin
                ccol = $urandom_range(0, 63);
                crow = $urandom_range(0, 31);
                cen  = ($urandom % 4) != 0;
            end
            hs = 1'($urandom);
            if ($urandom % 8 == 0) vs = ~vs;
            if ($urandom % 3 == 0) begin
                x = ccol * 8 + $urandom_range(0, 7);
                y = crow * 16 + $urandom_range(0, 15);
            end else begin
                x = $urandom_range(0, 511);
                y = $urandom_range(0, 287);
            end
            tick(($urandom % 8) != 0, hs, vs, x, y, cen, ccol, crow);
            total++;
            if (rgb_out !== exp_rgb) begin
                bad++; $display("FAIL rand_rgb n=%0d: got %h want %h", n, rgb_out, exp_rgb);
            end
            total++;
            if ({de_out, hsync_out, vsync_out} !== {exp_de, exp_hs, exp_vs}) begin
                bad++; $display("FAIL rand_sync n=%0d: got %b%b%b want %b%b%b", n,
                                de_out, hsync_out, vsync_out, exp_de, exp_hs, exp_vs);
            end
        end
        idle(3);
    endtask

    task automatic test_midline_reset();
        for (int i = 0; i < 4; i++) tick(1, 1, 1, 8 * i, 16, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (de_out !== 1'b0 || hsync_out !== 1'b0 || vsync_out !== 1'b0 || rgb_out !== 16'h0000) begin
            bad++; $display("FAIL async_rst_out: de=%b hs=%b vs=%b rgb=%h want 0/0/0/0000",
                            de_out, hsync_out, vsync_out, rgb_out);
        end
        total++;
        if (vram_ce !== 1'b0 || font_ce !== 1'b0 || font_ad !== 12'h000) begin
            bad++; $display("FAIL async_rst_ce: vce=%b fce=%b ad=%h want 0/0/000", vram_ce, font_ce, font_ad);
        end
        @(posedge clk); #1;
        de_in = 0; hsync_in = 0; vsync_in = 0; x_in = 0; y_in = 0;
        rst_n = 1'b1;
        model_reset();
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 9, 20, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (de_out !== 1'b0) begin bad++; $display("FAIL post_rst_early: got %b want 0", de_out); end
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (de_out !== 1'b1 || rgb_out !== exp_rgb) begin
            bad++; $display("FAIL post_rst_pix: de=%b rgb=%h want 1/%h", de_out, rgb_out, exp_rgb);
        end
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rst_n = 1'b0;
        de_in = 0; hsync_in = 0; vsync_in = 0; x_in = 0; y_in = 0;
        cursor_en = 0; cursor_col = 0; cursor_row = 0;
        model_reset();
        #12;
        test_reset();
        test_addr_map();
        test_glyph();
        test_out_of_area();
        test_cursor_blink();
        test_random();
        test_midline_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
